// File: rtl/dfg_pkg.sv
// -----------------------------------------------------------------------------
// dfg_pkg
// Shared definitions for the req/ack dataflow fabric.
//   DFG_DATA_WIDTH : default payload width of fabric words
//   DFG_FIFO_DEPTH : default number of entries of an elastic FIFO stage
//   hs_dir_e       : handshake side as seen by a monitor (sink or source)
// -----------------------------------------------------------------------------
package dfg_pkg;

    localparam int DFG_DATA_WIDTH = 32;
    localparam int DFG_FIFO_DEPTH = 4;

    typedef enum logic [0:0] {
        HS_DIR_SINK   = 1'b0,
        HS_DIR_SOURCE = 1'b1
    } hs_dir_e;

endpackage

// File: rtl/hs_fifo_mem.sv
// -----------------------------------------------------------------------------
// hs_fifo_mem
// Storage array for hs_fifo_buffer. The write is synchronous and the read is
// combinational, so the owner can register the head word in the same cycle
// that it decides to pop.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module hs_fifo_mem
    import dfg_pkg::*;
#(
    parameter int data_width = DFG_DATA_WIDTH,
    parameter int depth      = DFG_FIFO_DEPTH,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);

    // Contents need no reset: occupancy tracking makes stale entries unreachable.
    logic [data_width-1:0] mem_q [depth];

    // Single synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hs_fifo_buffer.sv
// -----------------------------------------------------------------------------
// hs_fifo_buffer
// Elastic FIFO stage for the req/ack dataflow fabric. The left side behaves as
// a sink (requests words from upstream), the right side as a source (answers
// downstream requests). Up to `depth` words are buffered.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req_l     : registered request for one word to upstream
//   ack_l/din : upstream one-cycle pulse with its data word
//   req_r     : downstream request
//   ack_r     : one-cycle pulse, new dout valid from this cycle
//   dout      : head word, held until the next ack_r
//   count     : occupancy 0..depth
//   overflow  : sticky, an ack_l arrived while full with no same-cycle pop
// Optional build macro HS_FIFO_STATS_EN adds:
//   push_total, pop_total (32-bit wrapping), max_count (high-water mark)
// -----------------------------------------------------------------------------
module hs_fifo_buffer
    import dfg_pkg::*;
#(
    parameter int data_width = DFG_DATA_WIDTH,
    parameter int depth      = DFG_FIFO_DEPTH,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req_l,
    input  logic                  ack_l,
    input  logic [data_width-1:0] din,
    input  logic                  req_r,
    output logic                  ack_r,
    output logic [data_width-1:0] dout,
    output logic [addr_width:0]   count,
    output logic                  overflow
`ifdef HS_FIFO_STATS_EN
    ,
    output logic [31:0]           push_total,
    output logic [31:0]           pop_total,
    output logic [addr_width:0]   max_count
`endif
);

    localparam logic [addr_width:0]   cnt_zero = (addr_width+1)'(0);
    localparam logic [addr_width:0]   cnt_one  = (addr_width+1)'(1);
    localparam logic [addr_width:0]   cnt_full = (addr_width+1)'(depth);
    // One slot stays free for an ack answering the previous request cycle.
    localparam logic [addr_width:0]   cnt_req  = (addr_width+1)'(depth - 2);
    localparam logic [addr_width-1:0] ptr_one  = addr_width'(1);

    logic                  req_l_q,    req_l_d;
    logic                  ack_r_q,    ack_r_d;
    logic [data_width-1:0] dout_q,     dout_d;
    logic [addr_width:0]   count_q,    count_d;
    logic                  overflow_q, overflow_d;
    logic [addr_width-1:0] rd_ptr_q,   rd_ptr_d;
    logic [addr_width-1:0] wr_ptr_q,   wr_ptr_d;

    logic                  push_en;
    logic                  pop_en;
    logic                  mem_we;
    logic [data_width-1:0] mem_rdata;

    // Handshake decisions and next-state computation for the core FIFO.
    always_comb begin
        // Pop only on a fresh request: the ~ack_r term limits pops to one per
        // two cycles, and using registered count means no empty bypass.
        pop_en     = req_r & ~ack_r_q & (count_q != cnt_zero);
        // A full FIFO still accepts a word when the head leaves in the same edge.
        push_en    = ack_l & ((count_q != cnt_full) | pop_en);

        overflow_d = overflow_q | (ack_l & (count_q == cnt_full) & ~pop_en);
        ack_r_d    = pop_en;

        if (pop_en) begin
            dout_d   = mem_rdata;
            rd_ptr_d = rd_ptr_q + ptr_one;
        end else begin
            dout_d   = dout_q;
            rd_ptr_d = rd_ptr_q;
        end

        if (push_en) begin
            wr_ptr_d = wr_ptr_q + ptr_one;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_en, pop_en})
            2'b10:   count_d = count_q + cnt_one;
            2'b01:   count_d = count_q - cnt_one;
            default: count_d = count_q;
        endcase

        req_l_d = (count_d <= cnt_req);
    end

    // Writes are blocked during reset so an ack in the reset cycle is ignored.
    assign mem_we = push_en & ~rst;

    hs_fifo_mem #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (addr_width)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    // Core state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_l_q    <= 1'b0;
            ack_r_q    <= 1'b0;
            dout_q     <= {data_width{1'b0}};
            count_q    <= cnt_zero;
            overflow_q <= 1'b0;
            rd_ptr_q   <= {addr_width{1'b0}};
            wr_ptr_q   <= {addr_width{1'b0}};
        end else begin
            req_l_q    <= req_l_d;
            ack_r_q    <= ack_r_d;
            dout_q     <= dout_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    assign req_l    = req_l_q;
    assign ack_r    = ack_r_q;
    assign dout     = dout_q;
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef HS_FIFO_STATS_EN
    logic [31:0]         push_total_q, push_total_d;
    logic [31:0]         pop_total_q,  pop_total_d;
    logic [addr_width:0] max_count_q,  max_count_d;

    // Statistics next-state: totals wrap naturally at 2^32.
    always_comb begin
        push_total_d = push_en ? (push_total_q + 32'd1) : push_total_q;
        pop_total_d  = pop_en  ? (pop_total_q + 32'd1)  : pop_total_q;
        if (count_d > max_count_q) begin
            max_count_d = count_d;
        end else begin
            max_count_d = max_count_q;
        end
    end

    // Statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_total_q <= 32'd0;
            pop_total_q  <= 32'd0;
            max_count_q  <= cnt_zero;
        end else begin
            push_total_q <= push_total_d;
            pop_total_q  <= pop_total_d;
            max_count_q  <= max_count_d;
        end
    end

    assign push_total = push_total_q;
    assign pop_total  = pop_total_q;
    assign max_count  = max_count_q;
`endif

endmodule

// File: doc/hs_fifo_buffer.md
Name: hs_fifo_buffer

Overview:
- Elastic FIFO stage for the req/ack dataflow fabric.
- Sits directly downstream of a dataflow graph's "out" operator and upstream of the consumer, or between any two operators.
- Decouples producer and consumer stalls by buffering up to `depth` words.
- Left side acts as a sink (requests data, like an operator input); right side acts as a source (answers requests, like a producer).

Parameters:
- `data_width`, 32, payload width in bits.
- `depth`, 4, number of storage entries; must be a power of 2 and >= 2.
- `addr_width`, $clog2(depth), pointer width; derived, do not override.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset.
- `req_l`  out  1  request to upstream for one word (registered).
- `ack_l`  in  1  upstream one-cycle pulse; `din` is valid in the same cycle.
- `din`  in  `data_width`  upstream data.
- `req_r`  in  1  downstream request.
- `ack_r`  out  1  one-cycle pulse; a new `dout` is valid from this cycle.
- `dout`  out  `data_width`  head word; held until the next `ack_r`.
- `count`  out  `addr_width`+1  current occupancy, 0..`depth`.
- `overflow`  out  1  sticky flag: an `ack_l` arrived while the FIFO was full.

Behaviour:
- Reset: `rst` is synchronous, active-high; clock is `clk`. On reset:
  - `req_l`=0, `ack_r`=0, `dout`=0, `count`=0, `overflow`=0.
  - Read and write pointers = 0.
  - Storage contents are don't-care.
- Push (every edge): `ack_l`=1 and (`count`<`depth` or a pop occurs in the same cycle) -> write `din` at `wr_ptr`, `wr_ptr`+1 mod `depth`.
- Overflow: `ack_l`=1 with `count`=`depth` and no same-cycle pop -> word dropped, `overflow`<=1 (held until reset), `count` unchanged.
- Pop (registered): `ack_r` defaults to 0 each cycle. If `req_r` & ~`ack_r` & (`count`>0):
  - `ack_r`<=1, `dout`<=mem[`rd_ptr`], `rd_ptr`+1 mod `depth`.
  - Consequence: at most one pop every 2 cycles.
- No empty bypass: a word pushed into an empty FIFO at edge t is popped at edge t+1 at the earliest (`ack_r` high one cycle after `ack_l`).
- `count` update per cycle: push only +1, pop only -1, both 0.
- `req_l` rule: `req_l` <= (`count_next` <= `depth`-2), where `count_next` is the post-update occupancy.
  - This leaves one slot for an ack already in flight from the previous request cycle.
  - `req_l` stays high continuously while space remains.
- Pointer wrap: pure modulo-`depth` increment; full/empty are derived from `count` only.
- Reset asserted mid-transfer:
  - Any `ack_l` in the reset cycle is ignored.
  - All state clears in the same edge.
  - An in-progress `ack_r` pulse is cut.

Optional Feature:
- Macro: HS_FIFO_STATS_EN.
- Defined: adds outputs `push_total` [31:0], `pop_total` [31:0] and `max_count` [`addr_width`:0].
  - All reset to 0.
  - `push_total` counts accepted pushes only; dropped overflow words are excluded.
  - `pop_total` counts `ack_r` pulses.
  - `max_count` is the high-water mark of `count`.
  - Both totals wrap at 2^32.
- Undefined: these ports and registers do not exist; the core behaviour is identical.

Decomposition:
- Shared package `dfg_pkg`: default `data_width` constant (32), default FIFO depth constant (4), and a handshake-direction enum used by bench monitors.
- Sub-module `hs_fifo_mem`: storage array with one synchronous write port and one combinational read port.
  - Ports: `clk`, `we`, `waddr`, `wdata`, `raddr`, `rdata`.
  - `hs_fifo_buffer` owns the pointers, counters and handshakes.

Test Plan:
- Reset: hold `rst` 2 cycles mid-stream with `count`=3 -> next cycle `count`=0, `ack_r`=0, `dout`=0, `req_l`=0, `overflow`=0; first post-reset `ack_r` carries the first post-reset word.
- Single word: empty FIFO, `ack_l` pulse with `din`=0xA5, `req_r`=1 -> `ack_r`=1 exactly one cycle later, `dout`=0xA5, `count` back to 0.
- Fill with stalled consumer: `depth`=4, `req_r`=0, standard producer -> `req_l` drops once `count` reaches 3; `count` peaks at 4 with no overflow.
- Wrap and order: stream 0..9 through `depth`=4, consumer on -> `dout` sequence exactly 0..9, `push_total`=`pop_total`=10 with HS_FIFO_STATS_EN.
- Overflow: force `ack_l`=1 with `din`=0xFF while `count`=4 and `req_r`=0 -> `overflow`=1 sticky, `count`=4, 0xFF never appears on `dout`.
- Simultaneous: `count`=4, same-cycle `ack_l` and pop -> `count` stays 4, no overflow, FIFO order preserved.
